// File: rtl/tx_frame_sender.sv
// tx_frame_sender: reads length-prefixed frames from a 4096 x 16 TX buffer
// RAM and transmits them on GMII as preamble, SFD and payload, followed by an
// inter-frame gap.
//
// Host/buffer pointer protocol: the host owns mem_wr_ptr and advances it past
// every word it has written; this block owns mem_rd_ptr and advances it only
// after a frame has been fully transmitted (or flushes it to mem_wr_ptr on a
// bad length word). Words between the two pointers are readable; everything
// else belongs to the host.
module tx_frame_sender #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tx_enable,
    input  logic [11:0] mem_wr_ptr,
    output logic [11:0] mem_rd_ptr,
    output logic [11:0] mem_rd_addr,
    input  logic [15:0] mem_rd_data,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic [15:0] frame_cnt,
    output logic        err_len,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_PRE   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_IFG   = 3'd5;

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

    logic [2:0]  state;
    logic        len_phase;   // LEN spends one cycle waiting for RAM latency
    logic [10:0] len_q;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_idx;
    logic [15:0] ifg_cnt;

    logic [11:0] avail;
    logic [11:0] words_needed;
    logic        start_ok;
    logic        len_bad;
    logic [7:0]  cur_byte;

    // Occupancy, frame size in words and the byte lane of the current word
    always_comb begin
        avail        = mem_wr_ptr - mem_rd_ptr;
        start_ok     = tx_enable && (avail != 12'd0);
        words_needed = 12'd1 + (({1'b0, len_q} + 12'd1) >> 1);
        len_bad      = (len_q < MIN_L) || (len_q > MAX_L);
        cur_byte     = byte_idx[0] ? mem_rd_data[15:8] : mem_rd_data[7:0];
    end

    assign dbg_state = state;

    // Frame sequencer: all outputs are registered here
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            len_phase   <= 1'b0;
            len_q       <= 11'd0;
            pre_cnt     <= 3'd0;
            byte_idx    <= 11'd0;
            ifg_cnt     <= 16'd0;
            mem_rd_ptr  <= 12'd0;
            mem_rd_addr <= 12'd0;
            gmii_txd    <= 8'h00;
            gmii_tx_en  <= 1'b0;
            frame_cnt   <= 16'd0;
            err_len     <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state       <= S_LEN;
                        len_phase   <= 1'b0;
                        mem_rd_addr <= mem_rd_ptr;
                    end
                end
                S_LEN: begin
                    if (!len_phase) begin
                        len_phase <= 1'b1;
                    end else begin
                        len_q <= mem_rd_data[10:0];
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (len_bad) begin
                        // Buffer contents can no longer be trusted: drop all of it
                        err_len    <= 1'b1;
                        mem_rd_ptr <= mem_wr_ptr;
                        state      <= S_IDLE;
                    end else if (avail >= words_needed) begin
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= 8'h55;
                        pre_cnt    <= 3'd1;
                        state      <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (pre_cnt == 3'd7) begin
                        gmii_txd <= 8'hD5;
                        byte_idx <= 11'd0;
                        state    <= S_DATA;
                    end else begin
                        gmii_txd <= 8'h55;
                        pre_cnt  <= pre_cnt + 3'd1;
                        // Two cycles ahead of the first payload byte
                        if (pre_cnt == 3'd6) begin
                            mem_rd_addr <= mem_rd_ptr + 12'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (byte_idx == len_q) begin
                        gmii_tx_en <= 1'b0;
                        gmii_txd   <= 8'h00;
                        mem_rd_ptr <= mem_rd_ptr + words_needed;
                        frame_cnt  <= frame_cnt + 16'd1;
                        ifg_cnt    <= 16'd0;
                        state      <= S_IFG;
                    end else begin
                        gmii_txd <= cur_byte;
                        byte_idx <= byte_idx + 11'd1;
                        // Sending a low byte: request the next word now so it
                        // lands right after the matching high byte goes out
                        if (!byte_idx[0]) begin
                            mem_rd_addr <= mem_rd_addr + 12'd1;
                        end
                    end
                end
                S_IFG: begin
                    if (ifg_cnt == IFG_LAST) begin
                        // Start decision folded into the last gap cycle so the
                        // back-to-back gap stays at IFG_BYTES+3
                        if (start_ok) begin
                            state       <= S_LEN;
                            len_phase   <= 1'b0;
                            mem_rd_addr <= mem_rd_ptr;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        ifg_cnt <= ifg_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_sender.sv
// tb_tx_frame_sender: buffer RAM model, directed boundary scenarios and a
// randomized frame sequence, with a byte/length scoreboard fed at load time
// and drained by an independent GMII monitor.
module tb_tx_frame_sender;

    localparam int IFG = 12;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        tx_enable;
    logic [11:0] mem_wr_ptr;
    logic [11:0] mem_rd_ptr;
    logic [11:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic [15:0] frame_cnt;
    logic        err_len;
    logic [2:0]  dbg_state;

    tx_frame_sender #(.IFG_BYTES(IFG), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .tx_enable   (tx_enable),
        .mem_wr_ptr  (mem_wr_ptr),
        .mem_rd_ptr  (mem_rd_ptr),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .frame_cnt   (frame_cnt),
        .err_len     (err_len),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset / RAM ----------------
    always #4 sys_clk = ~sys_clk;

    logic [15:0] mem [0:4095];
    always @(posedge sys_clk) mem_rd_data <= mem[mem_rd_addr];

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int         exp_len_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int en_run = 0, low_run = 0, last_gap = 0, rise_cyc = 0;
    int en_total = 0, bytes_seen = 0, err_run = 0, err_pulses = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge sys_clk) begin : monitor
        logic [7:0] b;
        int l;
        if (sys_rst) begin
            en_run  = 0;
            low_run = 0;
            err_run = 0;
        end else begin
            if (gmii_tx_en) begin
                if (en_run == 0) begin
                    last_gap = low_run;
                    rise_cyc = cyc;
                end
                low_run = 0;
                en_run++;
                en_total++;
                bytes_seen++;
                last_byte = gmii_txd;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL txd_extra: got 0x%0h with no byte expected (t=%0t)", gmii_txd, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("txd", {24'd0, gmii_txd}, {24'd0, b});
                end
            end else begin
                if (en_run > 0) begin
                    if (exp_len_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL en_len: got %0d enable cycles for an unexpected frame", en_run);
                    end else begin
                        l = exp_len_q.pop_front();
                        check("en_len", en_run, l);
                    end
                    check("txd_idle", {24'd0, gmii_txd}, 32'd0);
                    en_run = 0;
                end
                low_run++;
            end
            if (err_len) begin
                err_run++;
            end else if (err_run > 0) begin
                check("err_width", err_run, 1);
                err_pulses++;
                err_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst    = 1'b1;
        mem_wr_ptr = 12'd0;
        exp_q.delete();
        exp_len_q.delete();
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
    endtask

    // Writes a length word plus payload at base and queues the expected
    // GMII bytes and enable length when the length is in range.
    task automatic load_frame(input logic [11:0] base, input int len, input bit ramp,
                              input logic [4:0] top, output logic [11:0] words);
        logic [7:0] lo, hi;
        bit valid;
        valid = (len >= 64) && (len <= 1518);
        mem[base] = {top, 11'(len)};
        words = 12'(1 + (len + 1) / 2);
        if (valid) begin
            for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
            exp_q.push_back(8'hD5);
            exp_len_q.push_back(8 + len);
            for (int k = 0; k < (len + 1) / 2; k++) begin
                lo = ramp ? 8'(2 * k)     : 8'($urandom);
                hi = ramp ? 8'(2 * k + 1) : 8'($urandom);
                mem[12'(base + 1 + k)] = {hi, lo};
                exp_q.push_back(lo);
                if (2 * k + 1 < len) exp_q.push_back(hi);
            end
        end
    endtask

    task automatic wait_frames(input logic [15:0] target, input int budget);
        int n = 0;
        while (frame_cnt != target && n < budget) begin
            tick();
            n++;
        end
        check("frame_cnt_wait", {16'd0, frame_cnt}, {16'd0, target});
        repeat (IFG + 4) tick();
    endtask

    task automatic wait_err(input int target, input int budget);
        int n = 0;
        while (err_pulses != target && n < budget) begin
            tick();
            n++;
        end
        check("err_pulse_wait", err_pulses, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [11:0] w, m_rd, wr;
        logic [15:0] m_cnt;
        int c0, e0, p, b0, len, n;
        bit valid;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        sys_rst    = 1'b1;
        tx_enable  = 1'b0;
        mem_wr_ptr = 12'd0;
        repeat (2) tick();

        // Reset state
        check("rst_tx_en",    {31'd0, gmii_tx_en}, 32'd0);
        check("rst_txd",      {24'd0, gmii_txd},   32'd0);
        check("rst_rd_ptr",   {20'd0, mem_rd_ptr}, 32'd0);
        check("rst_rd_addr",  {20'd0, mem_rd_addr}, 32'd0);
        check("rst_frame_cnt",{16'd0, frame_cnt},  32'd0);
        check("rst_err_len",  {31'd0, err_len},    32'd0);
        sys_rst   = 1'b0;
        tx_enable = 1'b1;
        tick();

        // 64-byte ramp frame, start latency
        load_frame(12'h000, 64, 1'b1, 5'd0, w);
        c0 = cyc;
        mem_wr_ptr = 12'h021;
        wait_frames(16'd1, 400);
        check("start_latency", rise_cyc - c0, 4);
        check("f64_rd_ptr", {20'd0, mem_rd_ptr}, 32'h021);
        check("f64_drain", exp_q.size(), 0);

        // Odd length: trailing high byte suppressed
        do_reset();
        load_frame(12'h000, 65, 1'b0, 5'd0, w);
        mem_wr_ptr = 12'h022;
        wait_frames(16'd1, 400);
        check("f65_last_byte", {24'd0, last_byte}, {24'd0, mem[12'h021][7:0]});
        check("f65_rd_ptr", {20'd0, mem_rd_ptr}, 32'h022);

        // Back-to-back frames
        do_reset();
        load_frame(12'h000, 64, 1'b0, 5'd0, w);
        load_frame(12'h021, 64, 1'b0, 5'd0, w);
        mem_wr_ptr = 12'h042;
        wait_frames(16'd2, 800);
        check("b2b_gap", last_gap, IFG + 3);
        check("b2b_rd_ptr", {20'd0, mem_rd_ptr}, 32'h042);
        check("b2b_drain", exp_q.size(), 0);

        // Short length word: flush and error pulse, nothing sent
        do_reset();
        load_frame(12'h000, 16, 1'b0, 5'd0, w);
        e0 = en_total;
        p  = err_pulses;
        mem_wr_ptr = 12'h009;
        wait_err(p + 1, 50);
        repeat (5) tick();
        check("short_rd_ptr", {20'd0, mem_rd_ptr}, 32'h009);
        check("short_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("short_no_tx", en_total - e0, 0);

        // Pointer wrap: consume up to 0xFF0 via a flush, then send across 0xFFF
        do_reset();
        load_frame(12'h000, 16, 1'b0, 5'd0, w);
        p = err_pulses;
        mem_wr_ptr = 12'hFF0;
        wait_err(p + 1, 50);
        repeat (3) tick();
        check("wrap_pre_rd_ptr", {20'd0, mem_rd_ptr}, 32'hFF0);
        load_frame(12'hFF0, 64, 1'b0, 5'd0, w);
        mem_wr_ptr = 12'h011;
        wait_frames(16'd1, 400);
        check("wrap_rd_ptr", {20'd0, mem_rd_ptr}, 32'h011);
        check("wrap_drain", exp_q.size(), 0);

        // tx_enable gating, then CHECK waiting for the rest of the frame
        do_reset();
        tx_enable = 1'b0;
        load_frame(12'h000, 100, 1'b0, 5'd0, w);
        e0 = en_total;
        mem_wr_ptr = 12'h001;
        repeat (30) tick();
        check("gate_no_tx", en_total - e0, 0);
        tx_enable = 1'b1;
        repeat (40) tick();
        check("stall_no_tx", en_total - e0, 0);
        check("stall_rd_ptr", {20'd0, mem_rd_ptr}, 32'd0);
        mem_wr_ptr = 12'h033;
        wait_frames(16'd1, 400);
        check("stall_rd_ptr_done", {20'd0, mem_rd_ptr}, 32'h033);

        // Reset during payload byte 20, then a clean resend
        do_reset();
        load_frame(12'h000, 64, 1'b1, 5'd0, w);
        b0 = bytes_seen;
        mem_wr_ptr = 12'h021;
        n = 0;
        while (bytes_seen != b0 + 8 + 21 && n < 200) begin
            tick();
            n++;
        end
        check("rst_mid_reach", bytes_seen - b0, 29);
        sys_rst = 1'b1;
        #1;
        check("rst_mid_tx_en", {31'd0, gmii_tx_en}, 32'd0);
        check("rst_mid_rd_ptr", {20'd0, mem_rd_ptr}, 32'd0);
        exp_q.delete();
        exp_len_q.delete();
        mem_wr_ptr = 12'h000;
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
        load_frame(12'h000, 64, 1'b1, 5'd0, w);
        mem_wr_ptr = 12'h021;
        wait_frames(16'd1, 400);
        check("resend_rd_ptr", {20'd0, mem_rd_ptr}, 32'h021);
        check("resend_drain", exp_q.size(), 0);

        // Randomized sequence against the pointer/count model
        do_reset();
        m_rd  = 12'd0;
        m_cnt = 16'd0;
        p     = err_pulses;
        for (int it = 0; it < 14; it++) begin
            case (it)
                0: len = 1518;
                1: len = 63;
                2: len = 1519;
                3: len = 64;
                default: begin
                    if ($urandom_range(0, 4) == 0)
                        len = $urandom_range(0, 1) ? $urandom_range(1, 63) : $urandom_range(1519, 2047);
                    else
                        len = $urandom_range(64, 200);
                end
            endcase
            valid = (len >= 64) && (len <= 1518);
            load_frame(m_rd, len, 1'b0, 5'($urandom), w);
            if (valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    mem_wr_ptr = m_rd + 12'd1;
                    repeat (20) tick();
                end
                mem_wr_ptr = m_rd + w;
                if ($urandom_range(0, 1) == 1) begin
                    repeat (30) tick();
                    tx_enable = 1'b0;
                end
                m_cnt = m_cnt + 16'd1;
                m_rd  = m_rd + w;
                wait_frames(m_cnt, 3000);
                tx_enable = 1'b1;
            end else begin
                wr = m_rd + 12'(1 + $urandom_range(0, 4));
                mem_wr_ptr = wr;
                wait_err(p + 1, 50);
                p++;
                m_rd = wr;
                repeat (3) tick();
            end
            check("rand_rd_ptr", {20'd0, mem_rd_ptr}, {20'd0, m_rd});
            check("rand_frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        end
        check("rand_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
